// File: rtl/uart_multikey_transmitter.sv
// Keypad-to-UART transmitter: per-key edge queue, lowest-index arbitration, auto-repeat.
// Optional parity bit when UART_TX_PARITY_EN is defined.
module uart_multikey_transmitter #(
    parameter int DATA_WIDTH          = 8,
    parameter int NUM_KEYS            = 4,
    parameter logic [NUM_KEYS*DATA_WIDTH-1:0] KEY_CODES =
        {8'h77, 8'h64, 8'h73, 8'h61},
    parameter int BIT_COUNTER_WIDTH   = 3,
    parameter int CLOCK_COUNTER_WIDTH = 21,
    parameter int CLOCKS_PER_BIT      = 434,
    parameter int STOP_BITS           = 1,
`ifdef UART_TX_PARITY_EN
    parameter bit PARITY_ODD          = 1'b0,
`endif
    parameter int INTERFRAME_GAP      = 1608997
) (
    input  logic                i_clock,
    input  logic                i_resetL,
    input  logic [NUM_KEYS-1:0] i_keys,
    output logic                o_TX,
    output logic                o_busy,
    output logic                o_done,
    output logic [3:0]          o_key_idx
);

    localparam int CW = CLOCK_COUNTER_WIDTH;
    localparam int BW = BIT_COUNTER_WIDTH;
    localparam bit HAS_GAP = (INTERFRAME_GAP > 0);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLOCKS_PER_BIT * STOP_BITS - 1);
    localparam logic [CW-1:0] GAP_LAST  =
        CW'((INTERFRAME_GAP > 0) ? INTERFRAME_GAP - 1 : 0);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [3:0]              key_idx_q, key_idx_d;
    logic [NUM_KEYS-1:0]     s1_q, s1_d;
    logic [NUM_KEYS-1:0]     s2_q, s2_d;
    logic [NUM_KEYS-1:0]     prev_q, prev_d;
    logic [NUM_KEYS-1:0]     pending_q, pending_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [NUM_KEYS-1:0]     rise;
    logic [NUM_KEYS-1:0]     clr;
    logic [NUM_KEYS-1:0]     rep;
    logic                    frame_end;
    logic [3:0]              sel;

    // Lowest pending index wins.
    always_comb begin
        sel = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = 4'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        key_idx_d = key_idx_q;
        clr       = '0;
        frame_end = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|pending_q) begin
                    state_d   = S_START;
                    data_d    = KEY_CODES[sel*DATA_WIDTH +: DATA_WIDTH];
                    key_idx_d = sel;
                    clr       = NUM_KEYS'(1) << sel;
                end
            end
            S_START: begin
                if (cnt_q == BIT_LAST) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                    end else begin
                        state_d   = S_IDLE;
                        frame_end = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Held key re-arms itself as its own frame finishes.
    always_comb begin
        s1_d   = i_keys;
        s2_d   = s1_q;
        prev_d = s2_q;
        rise   = s2_q & ~prev_q;
        rep    = '0;
        if (frame_end) begin
            rep = s2_q & (NUM_KEYS'(1) << key_idx_q);
        end
        pending_d = ((pending_q | rise) & ~clr) | rep;
    end

    // Outputs are registered from next-state values to keep them glitch-free.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = (^data_d) ^ PARITY_ODD;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == STOP_LAST);
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            key_idx_q <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            key_idx_q <= key_idx_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_TX      = tx_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_key_idx = key_idx_q;

endmodule
